// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Sequencer that drives the 2-bit select of a 4-to-1 mux and samples the
//   mux output. On start it steps sel through channels 0..3, holding each
//   channel DWELL cycles, and samples mux_out on the last dwell cycle of each
//   channel. The four samples are packed into a 4-bit word (bit i = channel i)
//   and handed downstream with a valid/ready handshake. CONT selects one-shot
//   (back to idle after handoff) or continuous rescanning.
//
// Parameters
//   DWELL       cycles sel is held per channel before sampling (1..15)
//   CONT        0 = one-shot, 1 = rescan immediately after handoff
// Ports
//   clk         single clock, rising edge
//   rst         synchronous reset, active-high
//   start       scan request, sampled only while idle
//   mux_out     output of the mux being scanned
//   sel         mux select (channel currently being scanned)
//   busy        high whenever the sequencer is not idle
//   word        last completed scan
//   word_valid  word holds a new, unconsumed scan
//   word_ready  downstream accepts word when word_valid & word_ready

module mux_scan_ctrl #(
   parameter int DWELL = 2,
   parameter bit CONT  = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       mux_out,
   output logic [1:0] sel,
   output logic       busy,
   output logic [3:0] word,
   output logic       word_valid,
   input  logic       word_ready
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [3:0] CNT_LAST = 4'(DWELL - 1);

   state_t     state_reg, state_next;
   logic [1:0] sel_reg,   sel_next;
   logic [3:0] cnt_reg,   cnt_next;
   // Only channels 0..2 need storage; channel 3 goes straight into word.
   logic [2:0] cap_reg,   cap_next;
   logic [3:0] word_reg,  word_next;
   logic       valid_reg, valid_next;

   // One-hot decode of the channel being captured.
   logic [2:0] chan_hit;

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_hit
         assign chan_hit[gi] = (sel_reg == 2'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         sel_reg   <= 2'd0;
         cnt_reg   <= 4'd0;
         cap_reg   <= 3'd0;
         word_reg  <= 4'd0;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         sel_reg   <= sel_next;
         cnt_reg   <= cnt_next;
         cap_reg   <= cap_next;
         word_reg  <= word_next;
         valid_reg <= valid_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      sel_next   = sel_reg;
      cnt_next   = cnt_reg;
      cap_next   = cap_reg;
      word_next  = word_reg;
      valid_next = valid_reg;

      unique case (state_reg)
         IDLE: begin
            sel_next = 2'd0;
            cnt_next = 4'd0;
            if (start) begin
               state_next = SCAN;
            end
         end

         SCAN: begin
            if (cnt_reg == CNT_LAST) begin
               cnt_next = 4'd0;
               cap_next = (cap_reg & ~chan_hit) | ({3{mux_out}} & chan_hit);
               if (sel_reg != 2'd3) begin
                  sel_next = sel_reg + 2'd1;
               end else begin
                  // Word is only ever loaded with a complete scan.
                  word_next  = {mux_out, cap_reg};
                  valid_next = 1'b1;
                  sel_next   = 2'd0;
                  state_next = HOLD;
               end
            end else begin
               cnt_next = cnt_reg + 4'd1;
            end
         end

         HOLD: begin
            if (word_ready) begin
               valid_next = 1'b0;
               sel_next   = 2'd0;
               cnt_next   = 4'd0;
               state_next = CONT ? SCAN : IDLE;
            end
         end

         default: begin
            state_next = IDLE;
            sel_next   = 2'd0;
            cnt_next   = 4'd0;
            valid_next = 1'b0;
         end
      endcase
   end

   assign sel        = sel_reg;
   assign busy       = (state_reg != IDLE);
   assign word       = word_reg;
   assign word_valid = valid_reg;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed testbench for mux_scan_ctrl. Three instances are used:
//   u_os  DWELL=2, CONT=0
//   u_ct  DWELL=2, CONT=1
//   u_d1  DWELL=1, CONT=0
// Each mux is modelled as a=1, b=0, c=1, d=1 driven by the instance's own sel.

module tb_mux_scan_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a = 1'b1, b = 1'b0, c = 1'b1, d = 1'b1;
   logic [3:0] mux_in;

   logic       start_os = 1'b0, ready_os = 1'b0;
   logic       start_ct = 1'b0, ready_ct = 1'b0;
   logic       start_d1 = 1'b0, ready_d1 = 1'b0;
   logic [1:0] sel_os, sel_ct, sel_d1;
   logic       busy_os, busy_ct, busy_d1;
   logic [3:0] word_os, word_ct, word_d1;
   logic       valid_os, valid_ct, valid_d1;
   logic       mux_os, mux_ct, mux_d1;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   assign mux_in = {d, c, b, a};
   assign mux_os = mux_in[sel_os];
   assign mux_ct = mux_in[sel_ct];
   assign mux_d1 = mux_in[sel_d1];

   mux_scan_ctrl #(.DWELL(2), .CONT(1'b0)) u_os (
      .clk(clk), .rst(rst), .start(start_os), .mux_out(mux_os), .sel(sel_os),
      .busy(busy_os), .word(word_os), .word_valid(valid_os), .word_ready(ready_os));

   mux_scan_ctrl #(.DWELL(2), .CONT(1'b1)) u_ct (
      .clk(clk), .rst(rst), .start(start_ct), .mux_out(mux_ct), .sel(sel_ct),
      .busy(busy_ct), .word(word_ct), .word_valid(valid_ct), .word_ready(ready_ct));

   mux_scan_ctrl #(.DWELL(1), .CONT(1'b0)) u_d1 (
      .clk(clk), .rst(rst), .start(start_d1), .mux_out(mux_d1), .sel(sel_d1),
      .busy(busy_d1), .word(word_d1), .word_valid(valid_d1), .word_ready(ready_d1));

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start_os = 1'b1; start_ct = 1'b1; start_d1 = 1'b1;
      step(); step();
      tests_run++;
      if ({sel_os, word_os, valid_os, busy_os} !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_os: got sel/word/valid/busy=%h, expected 00", {sel_os, word_os, valid_os, busy_os});
      end
      tests_run++;
      if ({sel_ct, word_ct, valid_ct, busy_ct} !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_ct: got sel/word/valid/busy=%h, expected 00", {sel_ct, word_ct, valid_ct, busy_ct});
      end
      tests_run++;
      if ({sel_d1, word_d1, valid_d1, busy_d1} !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_d1: got sel/word/valid/busy=%h, expected 00", {sel_d1, word_d1, valid_d1, busy_d1});
      end
      rst = 1'b0; start_os = 1'b0; start_ct = 1'b0; start_d1 = 1'b0;
      step();
      tests_run++;
      if ({busy_os, busy_ct, busy_d1} !== 3'b000) begin
         tests_failed++;
         $display("FAIL reset_no_scan: got busy=%b, expected 000", {busy_os, busy_ct, busy_d1});
      end
      $display("[TB] reset: done");
   endtask

   task automatic test_one_shot();
      start_os = 1'b1;
      step();
      start_os = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tests_run++;
         if (sel_os !== 2'(k / 2) || valid_os !== 1'b0 || busy_os !== 1'b1) begin
            tests_failed++;
            $display("FAIL oneshot_seq[%0d]: got sel=%0d valid=%b busy=%b, expected sel=%0d valid=0 busy=1",
                     k, sel_os, valid_os, busy_os, k / 2);
         end
         step();
      end
      tests_run++;
      if (valid_os !== 1'b1 || word_os !== 4'b1101 || busy_os !== 1'b1) begin
         tests_failed++;
         $display("FAIL oneshot_word: got valid=%b word=%b busy=%b, expected valid=1 word=1101 busy=1",
                  valid_os, word_os, busy_os);
      end
      for (int k = 0; k < 5; k++) begin
         step();
         tests_run++;
         if (valid_os !== 1'b1 || word_os !== 4'b1101 || sel_os !== 2'd0) begin
            tests_failed++;
            $display("FAIL oneshot_hold[%0d]: got valid=%b word=%b sel=%0d, expected valid=1 word=1101 sel=0",
                     k, valid_os, word_os, sel_os);
         end
      end
      ready_os = 1'b1;
      step();
      ready_os = 1'b0;
      tests_run++;
      if (valid_os !== 1'b0 || busy_os !== 1'b0 || word_os !== 4'b1101) begin
         tests_failed++;
         $display("FAIL oneshot_handoff: got valid=%b busy=%b word=%b, expected valid=0 busy=0 word=1101",
                  valid_os, busy_os, word_os);
      end
      $display("[TB] one_shot: word=%b", word_os);
   endtask

   task automatic test_mid_reset();
      start_os = 1'b1;
      step();
      start_os = 1'b0;
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      tests_run++;
      if ({sel_os, word_os, valid_os, busy_os} !== 8'h00) begin
         tests_failed++;
         $display("FAIL midreset_state: got sel/word/valid/busy=%h, expected 00", {sel_os, word_os, valid_os, busy_os});
      end
      for (int k = 0; k < 4; k++) begin
         step();
         tests_run++;
         if (valid_os !== 1'b0 || busy_os !== 1'b0 || word_os !== 4'b0000) begin
            tests_failed++;
            $display("FAIL midreset_idle[%0d]: got valid=%b busy=%b word=%b, expected 0 0 0000",
                     k, valid_os, busy_os, word_os);
         end
      end
      start_os = 1'b1;
      step();
      start_os = 1'b0;
      for (int k = 0; k < 7; k++) begin
         step();
         tests_run++;
         if (valid_os !== 1'b0 || word_os !== 4'b0000) begin
            tests_failed++;
            $display("FAIL midreset_rescan[%0d]: got valid=%b word=%b, expected valid=0 word=0000",
                     k, valid_os, word_os);
         end
      end
      step();
      tests_run++;
      if (valid_os !== 1'b1 || word_os !== 4'b1101) begin
         tests_failed++;
         $display("FAIL midreset_word: got valid=%b word=%b, expected valid=1 word=1101", valid_os, word_os);
      end
      ready_os = 1'b1;
      step();
      ready_os = 1'b0;
      $display("[TB] mid_reset: word=%b", word_os);
   endtask

   task automatic test_ignored();
      // word_ready while idle must have no effect.
      ready_os = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         tests_run++;
         if (valid_os !== 1'b0 || busy_os !== 1'b0 || word_os !== 4'b1101) begin
            tests_failed++;
            $display("FAIL ignored_ready_idle[%0d]: got valid=%b busy=%b word=%b, expected 0 0 1101",
                     k, valid_os, busy_os, word_os);
         end
      end
      ready_os = 1'b0;
      start_os = 1'b1;
      step();
      start_os = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tests_run++;
         if (sel_os !== 2'(k / 2) || valid_os !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignored_scan[%0d]: got sel=%0d valid=%b, expected sel=%0d valid=0",
                     k, sel_os, valid_os, k / 2);
         end
         start_os = (k == 2 || k == 5);
         step();
         start_os = 1'b0;
      end
      tests_run++;
      if (valid_os !== 1'b1 || word_os !== 4'b1101) begin
         tests_failed++;
         $display("FAIL ignored_word: got valid=%b word=%b, expected valid=1 word=1101", valid_os, word_os);
      end
      start_os = 1'b1;
      for (int k = 0; k < 2; k++) begin
         step();
         tests_run++;
         if (valid_os !== 1'b1 || word_os !== 4'b1101 || sel_os !== 2'd0) begin
            tests_failed++;
            $display("FAIL ignored_hold[%0d]: got valid=%b word=%b sel=%0d, expected 1 1101 0",
                     k, valid_os, word_os, sel_os);
         end
      end
      start_os = 1'b0;
      ready_os = 1'b1;
      step();
      ready_os = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tests_run++;
         if (valid_os !== 1'b0 || busy_os !== 1'b0) begin
            tests_failed++;
            $display("FAIL ignored_no_restart[%0d]: got valid=%b busy=%b, expected 0 0", k, valid_os, busy_os);
         end
         step();
      end
      $display("[TB] ignored_inputs: done");
   endtask

   task automatic test_dwell1();
      start_d1 = 1'b1;
      step();
      start_d1 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tests_run++;
         if (sel_d1 !== 2'(k) || valid_d1 !== 1'b0 || busy_d1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL dwell1_seq[%0d]: got sel=%0d valid=%b busy=%b, expected sel=%0d valid=0 busy=1",
                     k, sel_d1, valid_d1, busy_d1, k);
         end
         step();
      end
      tests_run++;
      if (valid_d1 !== 1'b1 || word_d1 !== 4'b1101) begin
         tests_failed++;
         $display("FAIL dwell1_word: got valid=%b word=%b, expected valid=1 word=1101", valid_d1, word_d1);
      end
      ready_d1 = 1'b1;
      step();
      ready_d1 = 1'b0;
      tests_run++;
      if (valid_d1 !== 1'b0 || busy_d1 !== 1'b0) begin
         tests_failed++;
         $display("FAIL dwell1_handoff: got valid=%b busy=%b, expected 0 0", valid_d1, busy_d1);
      end
      $display("[TB] dwell1: word=%b", word_d1);
   endtask

   task automatic test_continuous();
      logic       exp_valid;
      logic [3:0] exp_word;
      ready_ct = 1'b1;
      start_ct = 1'b1;
      step();
      start_ct = 1'b0;
      // n counts edges after the accepting edge; words complete at n = 8, 17, 26, 35.
      for (int n = 0; n <= 35; n++) begin
         if (n == 18) d = 1'b0;
         exp_valid = (n % 9 == 8);
         exp_word  = (n < 26) ? 4'b1101 : 4'b0101;
         tests_run++;
         if (valid_ct !== exp_valid || busy_ct !== 1'b1) begin
            tests_failed++;
            $display("FAIL cont_valid[%0d]: got valid=%b busy=%b, expected valid=%b busy=1",
                     n, valid_ct, busy_ct, exp_valid);
         end
         if (exp_valid) begin
            tests_run++;
            if (word_ct !== exp_word) begin
               tests_failed++;
               $display("FAIL cont_word[%0d]: got word=%b, expected %b", n, word_ct, exp_word);
            end
            $display("[TB] continuous: word at edge %0d = %b", n, word_ct);
         end
         step();
      end
      ready_ct = 1'b0;
      d = 1'b1;
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_mid_reset();
      test_ignored();
      test_dwell1();
      test_continuous();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
